// File: rtl/apb_arb_pkg.sv
// Shared types and default widths for the two-requester APB arbiter.
package apb_arb_pkg;

  localparam int ADDR_WIDTH_DEF     = 32;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  // Arbiter / bridge handshake FSM.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Transfer size carried on reqN_dsel / m_dsel.
  typedef enum logic [1:0] {
    FULLWORD = 2'd0,
    HALFWORD = 2'd1,
    BYTE     = 2'd2
  } dsel_type;

endpackage

// File: rtl/apb_arb_rr.sv
// Two-way round-robin picker: combinational winner selection from the valids
// and the remembered last grant; last_grant updates only when a grant is taken.
module apb_arb_rr
  import apb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       grant_en,
  output logic       grant_idx,
  output logic       grant_any
);

  logic last_grant;

  // On a tie the requester that did not win last time gets the bus.
  always_comb begin
    grant_any = |valid;
    grant_idx = 1'b0;
    if (valid == 2'b11) begin
      grant_idx = ~last_grant;
    end else if (valid[1]) begin
      grant_idx = 1'b1;
    end
  end

  // Reset to 1 so requester 0 wins the first tie after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant_en) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester front end for an APB bridge: arbitrates, issues one
// SETUP/ACCESS transfer at a time and returns the response to the winner.
// Optional feature: define APB_ARB_TIMEOUT_EN to force an error response after
// TIMEOUT_CYCLES ACCESS cycles without m_ready; otherwise ACCESS waits forever.
module apb_arbiter
  import apb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  req0_valid,
  input  logic                  req0_wr,
  input  logic [1:0]            req0_dsel,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ack,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,

  input  logic                  req1_valid,
  input  logic                  req1_wr,
  input  logic [1:0]            req1_dsel,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ack,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,

  output logic                  m_trnsfr,
  output logic                  m_wr,
  output logic [1:0]            m_dsel,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [DATA_WIDTH-1:0] m_data_in,
  input  logic [DATA_WIDTH-1:0] m_data_out,
  input  logic                  m_ready,
  input  logic                  m_slverr
);

  arb_state_t            state;
  arb_state_t            next_state;

  logic                  grant_idx;
  logic                  grant_any;
  logic                  grant_en;
  logic                  grant_q;

  logic                  wr_q;
  logic [1:0]            dsel_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  rsp_en;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;
  logic                  err0_q;
  logic                  err1_q;

  apb_arb_rr u_rr (
    .clk       (clk),
    .rst       (rst),
    .valid     ({req1_valid, req0_valid}),
    .grant_en  (grant_en),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic            rsp_timeout;

  assign timeout_hit = (to_cnt == TO_LAST);

  // Count ACCESS cycles without m_ready; cleared while in SETUP so every
  // ACCESS phase starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if ((state == ACCESS) && !m_ready && !timeout_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the grant and response strobes it implies.
  always_comb begin
    next_state = state;
    grant_en   = 1'b0;
    rsp_en     = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    rsp_timeout = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (grant_any) begin
          grant_en   = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP: begin
        next_state = ACCESS;
      end
      ACCESS: begin
        if (m_ready) begin
          rsp_en     = 1'b1;
          next_state = RESP;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          rsp_en      = 1'b1;
          rsp_timeout = 1'b1;
          next_state  = RESP;
        end
`endif
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Latch the winner's fields at grant; they drive the bridge for the whole
  // transfer so requesters may change theirs right after ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= 1'b0;
      wr_q    <= 1'b0;
      dsel_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_en) begin
      grant_q <= grant_idx;
      wr_q    <= grant_idx ? req1_wr    : req0_wr;
      dsel_q  <= grant_idx ? req1_dsel  : req0_dsel;
      addr_q  <= grant_idx ? req1_addr  : req0_addr;
      wdata_q <= grant_idx ? req1_wdata : req0_wdata;
    end
  end

  // Response value: writes return zero data; a timeout reports error, no data.
  always_comb begin
    rsp_rdata = wr_q ? '0 : m_data_out;
    rsp_err   = m_slverr;
`ifdef APB_ARB_TIMEOUT_EN
    if (rsp_timeout) begin
      rsp_rdata = '0;
      rsp_err   = 1'b1;
    end
`endif
  end

  // Store the response for the granted requester; held until its next done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else if (rsp_en) begin
      if (grant_q) begin
        rdata1_q <= rsp_rdata;
        err1_q   <= rsp_err;
      end else begin
        rdata0_q <= rsp_rdata;
        err0_q   <= rsp_err;
      end
    end
  end

  // Handshake outputs decode straight from state so reset clears them at once.
  assign m_trnsfr  = (state == SETUP) || (state == ACCESS);
  assign m_wr      = wr_q;
  assign m_dsel    = dsel_q;
  assign m_address = addr_q;
  assign m_data_in = wdata_q;

  assign req0_ack   = (state == SETUP) && !grant_q;
  assign req1_ack   = (state == SETUP) &&  grant_q;
  assign req0_done  = (state == RESP)  && !grant_q;
  assign req1_done  = (state == RESP)  &&  grant_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign req0_err   = err0_q;
  assign req1_err   = err1_q;

endmodule

// File: tb/tb_apb_arbiter.sv
`timescale 1ns/1ps
module tb_apb_arbiter;
  import apb_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req0_wr, req0_ack, req0_done, req0_err;
  logic [1:0]    req0_dsel;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_wr, req1_ack, req1_done, req1_err;
  logic [1:0]    req1_dsel;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic          m_trnsfr, m_wr, m_ready, m_slverr;
  logic [1:0]    m_dsel;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_data_in, m_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  apb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_dsel(req0_dsel),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ack(req0_ack),
    .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_dsel(req1_dsel),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ack(req1_ack),
    .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_err(req1_err),
    .m_trnsfr(m_trnsfr), .m_wr(m_wr), .m_dsel(m_dsel), .m_address(m_address),
    .m_data_in(m_data_in), .m_data_out(m_data_out), .m_ready(m_ready),
    .m_slverr(m_slverr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] ctl;
    rst = 1'b1;
    req0_valid = 0; req0_wr = 0; req0_dsel = 2'b00; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_wr = 0; req1_dsel = 2'b00; req1_addr = '0; req1_wdata = '0;
    m_data_out = '0; m_ready = 1'b1; m_slverr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ctl = {m_trnsfr, m_wr, m_dsel, req0_ack, req1_ack, req0_done, req1_done, req0_err, req1_err};
    n_checks++;
    if (ctl !== 10'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 0000000000", ctl);
    end
    n_checks++;
    if ({m_address, m_data_in, req0_rdata, req1_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: addr %h din %h rd0 %h rd1 %h want all 0",
                         m_address, m_data_in, req0_rdata, req1_rdata);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({m_trnsfr, req0_ack, req1_ack} !== 3'b000) begin
      n_fail++; $display("FAIL idle_no_valid: got %b want 000", {m_trnsfr, req0_ack, req1_ack});
    end
  endtask

  task automatic test_write();
    req0_valid = 1; req0_wr = 1; req0_dsel = FULLWORD;
    req0_addr = 32'h0000_00F0; req0_wdata = 32'h000A_3210;
    tick(); // SETUP
    n_checks++;
    if ({req0_ack, req1_ack, m_trnsfr} !== 3'b101) begin
      n_fail++; $display("FAIL wr_ack_setup: ack0/ack1/trnsfr %b want 101", {req0_ack, req1_ack, m_trnsfr});
    end
    n_checks++;
    if (m_address !== 32'hF0 || m_data_in !== 32'h000A3210 || m_wr !== 1'b1 || m_dsel !== 2'd0) begin
      n_fail++; $display("FAIL wr_bus: addr %h din %h wr %b dsel %0d want f0 000a3210 1 0",
                         m_address, m_data_in, m_wr, m_dsel);
    end
    req0_valid = 0; req0_addr = 32'hDEAD; req0_wdata = 32'hBAD;
    tick(); // ACCESS
    n_checks++;
    if ({req0_ack, m_trnsfr, req0_done} !== 3'b010 || m_address !== 32'hF0 || m_data_in !== 32'h000A3210) begin
      n_fail++; $display("FAIL wr_access: ack0/trnsfr/done0 %b addr %h want 010 f0", {req0_ack, m_trnsfr, req0_done}, m_address);
    end
    tick(); // RESP
    n_checks++;
    if ({req0_done, req1_done, req0_err, m_trnsfr} !== 4'b1000 || req0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL wr_done: done0/done1/err0/trnsfr %b rdata0 %h want 1000 0",
                         {req0_done, req1_done, req0_err, m_trnsfr}, req0_rdata);
    end
    tick(); // IDLE
    n_checks++;
    if (req0_done !== 1'b0) begin
      n_fail++; $display("FAIL wr_done_pulse: done0 %b want 0", req0_done);
    end
  endtask

  task automatic test_read();
    req1_valid = 1; req1_wr = 0; req1_dsel = HALFWORD; req1_addr = 32'h12;
    m_data_out = 32'h0000_CB29;
    tick(); // SETUP
    n_checks++;
    if ({req1_ack, req0_ack, m_wr, m_dsel} !== 5'b10001 || m_address !== 32'h12) begin
      n_fail++; $display("FAIL rd_setup: ack1/ack0/wr/dsel %b addr %h want 10001 12",
                         {req1_ack, req0_ack, m_wr, m_dsel}, m_address);
    end
    req1_valid = 0;
    tick(); // ACCESS
    tick(); // RESP
    n_checks++;
    if ({req1_done, req0_done, req1_err} !== 3'b100 || req1_rdata !== 32'h0000CB29) begin
      n_fail++; $display("FAIL rd_done: done1/done0/err1 %b rdata1 %h want 100 0000cb29",
                         {req1_done, req0_done, req1_err}, req1_rdata);
    end
    n_checks++;
    if (req0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rd_other_hold: rdata0 %h want 0", req0_rdata);
    end
    m_data_out = 32'h5555_5555;
    tick(); // IDLE
    n_checks++;
    if (req1_rdata !== 32'h0000CB29) begin
      n_fail++; $display("FAIL rd_hold: rdata1 %h want 0000cb29", req1_rdata);
    end
  endtask

  task automatic test_slverr();
    req0_valid = 1; req0_wr = 0; req0_dsel = FULLWORD; req0_addr = 32'h0100;
    m_data_out = 32'h1234; m_slverr = 1'b1;
    tick(); // SETUP
    req0_valid = 0;
    tick(); // ACCESS
    tick(); // RESP
    n_checks++;
    if ({req0_done, req0_err} !== 2'b11 || req0_rdata !== 32'h1234) begin
      n_fail++; $display("FAIL slverr_done: done0/err0 %b rdata0 %h want 11 1234", {req0_done, req0_err}, req0_rdata);
    end
    m_slverr = 1'b0;
    tick(); // IDLE
    n_checks++;
    if (req0_err !== 1'b1) begin
      n_fail++; $display("FAIL slverr_hold: err0 %b want 1", req0_err);
    end
  endtask

  task automatic test_back_to_back();
    int order[$];
    int exp_order[6] = '{0, 1, 0, 1, 0, 1};
    int cnt0 = 0;
    int cnt1 = 0;
    int cyc  = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    req0_valid = 1; req0_wr = 1; req0_addr = 32'h1000; req0_wdata = 32'hA0;
    req1_valid = 1; req1_wr = 1; req1_addr = 32'h2000; req1_wdata = 32'hB1;
    while ((cnt0 < 3 || cnt1 < 3) && cyc < 200) begin
      tick();
      cyc++;
      if (req0_ack && req1_ack) begin
        n_checks++; n_fail++; $display("FAIL b2b_dual_ack: both acks high at cycle %0d", cyc);
      end
      if (req0_ack) begin
        order.push_back(0); cnt0++;
        n_checks++;
        if (m_address !== 32'h1000) begin
          n_fail++; $display("FAIL b2b_addr0: addr %h want 1000", m_address);
        end
        if (cnt0 == 3) req0_valid = 0;
      end
      if (req1_ack) begin
        order.push_back(1); cnt1++;
        n_checks++;
        if (m_address !== 32'h2000) begin
          n_fail++; $display("FAIL b2b_addr1: addr %h want 2000", m_address);
        end
        if (cnt1 == 3) req1_valid = 0;
      end
      if (req0_done || req1_done) begin
        n_checks++;
        if (m_trnsfr !== 1'b0) begin
          n_fail++; $display("FAIL b2b_trnsfr_gap: trnsfr %b want 0 at cycle %0d", m_trnsfr, cyc);
        end
      end
    end
    n_checks++;
    if (cyc != 21) begin
      n_fail++; $display("FAIL b2b_cycles: last ack at cycle %0d want 21", cyc);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i >= order.size()) begin
        n_fail++; $display("FAIL b2b_order[%0d]: missing grant want %0d", i, exp_order[i]);
      end else if (order[i] != exp_order[i]) begin
        n_fail++; $display("FAIL b2b_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]);
      end
    end
    tick(); // ACCESS
    tick(); // RESP
    n_checks++;
    if ({req1_done, req0_done} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_last_done: done1/done0 %b want 10", {req1_done, req0_done});
    end
    tick(); // IDLE
  endtask

  task automatic test_timeout();
    logic seen_done;
    req0_valid = 1; req0_wr = 0; req0_addr = 32'h40;
    m_data_out = 32'h7777; m_ready = 1'b0;
    tick(); // SETUP
    req0_valid = 0;
    seen_done = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      tick(); // ACCESS cycles 1..16
      if (req0_done || req1_done) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done || m_trnsfr !== 1'b1) begin
      n_fail++; $display("FAIL to_early: done seen %b trnsfr %b want 0 1", seen_done, m_trnsfr);
    end
    tick(); // RESP
    n_checks++;
    if ({req0_done, req0_err, m_trnsfr} !== 3'b110 || req0_rdata !== 32'h0) begin
      n_fail++; $display("FAIL to_done: done0/err0/trnsfr %b rdata0 %h want 110 0",
                         {req0_done, req0_err, m_trnsfr}, req0_rdata);
    end
    m_ready = 1'b1;
    tick(); // IDLE
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      if (req0_done || req1_done || !m_trnsfr) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) begin
      n_fail++; $display("FAIL no_to_wait: done or trnsfr drop seen %b want 0", seen_done);
    end
    m_data_out = 32'hBEEF; m_ready = 1'b1;
    tick(); // RESP
    n_checks++;
    if ({req0_done, req0_err} !== 2'b10 || req0_rdata !== 32'hBEEF) begin
      n_fail++; $display("FAIL no_to_done: done0/err0 %b rdata0 %h want 10 beef", {req0_done, req0_err}, req0_rdata);
    end
    tick(); // IDLE
`endif
  endtask

  task automatic test_reset_midflight();
    logic [9:0] ctl;
    logic       seen_done;
    req1_valid = 1; req1_wr = 0; req1_addr = 32'h80; m_ready = 1'b0;
    tick(); // SETUP
    req1_valid = 0;
    tick(); // ACCESS 1
    tick(); // ACCESS 2
    rst = 1'b1;
    #1;
    ctl = {m_trnsfr, m_wr, m_dsel, req0_ack, req1_ack, req0_done, req1_done, req0_err, req1_err};
    n_checks++;
    if (ctl !== 10'b0 || {m_address, m_data_in, req0_rdata, req1_rdata} !== '0) begin
      n_fail++; $display("FAIL mid_rst_outputs: ctl %b addr %h rd0 %h want 0 0 0", ctl, m_address, req0_rdata);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (req0_done || req1_done || m_trnsfr) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done) begin
      n_fail++; $display("FAIL mid_rst_abandon: done/trnsfr seen %b want 0", seen_done);
    end
    req0_valid = 1; req1_valid = 1;
    tick(); // SETUP
    n_checks++;
    if ({req0_ack, req1_ack} !== 2'b10) begin
      n_fail++; $display("FAIL mid_rst_first_tie: ack0/ack1 %b want 10", {req0_ack, req1_ack});
    end
    req0_valid = 0; req1_valid = 0;
    tick(); // ACCESS
    tick(); // RESP
    n_checks++;
    if ({req0_done, req1_done} !== 2'b10) begin
      n_fail++; $display("FAIL mid_rst_done: done0/done1 %b want 10", {req0_done, req1_done});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_slverr();
    test_back_to_back();
    test_timeout();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
